// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions used by the decode-side register scoreboard.
package rv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_t;

    // Writes to x0 never create a hazard, so they are tracked as non-writing entries.
    function automatic sb_entry_t make_entry(logic we, logic [REG_ADDR_W-1:0] rd);
        sb_entry_t e;
        e.we = we && (rd != X0);
        e.rd = rd;
        return e;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback handshake bundle between the pipeline and the register scoreboard.
interface regfile_scoreboard_if #(
    parameter int DEPTH = 4
);
    import rv32_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic                  issue_valid;
    logic                  issue_we;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  retire_valid;
    logic [REG_ADDR_W-1:0] retire_rd;
    logic                  retire_we;
    logic [PTR_W:0]        flush_cnt;
    logic                  stall;
    logic [PTR_W:0]        inflight;
    logic                  full;
    logic                  order_err;

    modport master (
        output issue_valid, issue_we, issue_rd, rs1, rs2, use_rs1, use_rs2,
        output retire_valid, retire_rd, retire_we, flush_cnt,
        input  stall, inflight, full, order_err
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, rs1, rs2, use_rs1, use_rs2,
        input  retire_valid, retire_rd, retire_we, flush_cnt,
        output stall, inflight, full, order_err
    );

endinterface

// File: rtl/regfile_scoreboard_sb_fifo.sv
// sb_fifo: circular FIFO of scoreboard entries with push, pop and rollback of the
// youngest n entries; exposes every slot plus a live mask for the hazard compare.
module sb_fifo
    import rv32_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  sb_entry_t             push_data,
    input  logic                  pop,
    input  logic [PTR_W:0]        rollback,
    input  logic                  hide_head,
    output sb_entry_t             head_data,
    output sb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      live,
    output logic [PTR_W:0]        count
);

    sb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      tail_next;
    logic [PTR_W:0]        count_next;
    logic [PTR_W:0]        avail;
    logic [PTR_W:0]        kill;
    logic                  do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = mem[head];
    assign entries   = mem;

    // Rollback can only remove entries that survive this cycle's pop.
    always_comb begin
        avail      = count - (PTR_W+1)'(do_pop);
        kill       = (rollback < avail) ? rollback : avail;
        tail_next  = tail + PTR_W'(push) - kill[PTR_W-1:0];
        count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop) - kill;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
            end
            head  <= head + PTR_W'(do_pop);
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_live
        logic [PTR_W-1:0] off;
        assign off     = PTR_W'(i) - head;
        assign live[i] = ({1'b0, off} < count) && !(hide_head && (off == '0));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// In-order destination-register scoreboard for decode. Optional macro
// SCOREBOARD_SAME_CYCLE_RELEASE_EN lets a retiring head entry stop blocking in its retire cycle.
module regfile_scoreboard
    import rv32_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    regfile_scoreboard_if.slave sb
);

    sb_entry_t             head_data;
    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      live;
    logic [PTR_W:0]        count;
    logic                  hit1;
    logic                  hit2;
    logic                  full;
    logic                  stall;
    logic                  push;
    logic                  pop;
    logic                  hide_head;
    logic                  order_err;

`ifdef SCOREBOARD_SAME_CYCLE_RELEASE_EN
    // The register file writes on negedge, so the retiring value is readable this cycle.
    assign hide_head = sb.retire_valid;
`else
    assign hide_head = 1'b0;
`endif

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (make_entry(sb.issue_we, sb.issue_rd)),
        .pop       (pop),
        .rollback  (sb.flush_cnt),
        .hide_head (hide_head),
        .head_data (head_data),
        .entries   (entries),
        .live      (live),
        .count     (count)
    );

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && entries[i].we) begin
                if (entries[i].rd == sb.rs1) hit1 = 1'b1;
                if (entries[i].rd == sb.rs2) hit2 = 1'b1;
            end
        end
        hit1 = hit1 && sb.use_rs1 && (sb.rs1 != X0);
        hit2 = hit2 && sb.use_rs2 && (sb.rs2 != X0);
    end

    // A full tracker still accepts an issue when the oldest entry retires alongside it.
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign stall = sb.issue_valid &&
                   (hit1 || hit2 || (full && !sb.retire_valid) || (sb.flush_cnt != '0));
    assign push  = sb.issue_valid && !stall;
    assign pop   = sb.retire_valid && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            order_err <= 1'b0;
        end else if (sb.retire_valid &&
                     ((count == '0) ||
                      (head_data.we != sb.retire_we) ||
                      (head_data.rd != sb.retire_rd))) begin
            order_err <= 1'b1;
        end
    end

    assign sb.stall     = stall;
    assign sb.inflight  = count;
    assign sb.full      = full;
    assign sb.order_err = order_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic, checked by a
// queue-based reference model through a decoupled monitor.
module tb_regfile_scoreboard;
    import rv32_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.DEPTH(DEPTH)) sb ();

    regfile_scoreboard #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    typedef struct {
        bit       we;
        bit [4:0] rd;
    } ent_t;

    typedef struct {
        bit    stall;
        int    inflight;
        bit    full;
        bit    err;
        string tag;
    } exp_t;

    ent_t model[$];
    bit   model_err = 1'b0;
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic checkOutput(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares each cycle's outputs against the expectation queued for it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.tag, ".stall"},    int'(sb.stall),     int'(e.stall));
                checkOutput({e.tag, ".inflight"}, int'(sb.inflight),  e.inflight);
                checkOutput({e.tag, ".full"},     int'(sb.full),      int'(e.full));
                checkOutput({e.tag, ".err"},      int'(sb.order_err), int'(e.err));
            end
        end
    end

    function automatic bit modelHit(bit [4:0] rs, bit rv);
        if (rs == 5'd0) return 1'b0;
        foreach (model[i]) begin
`ifdef SCOREBOARD_SAME_CYCLE_RELEASE_EN
            if (i == 0 && rv) continue;
`endif
            if (model[i].we && model[i].rd == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus(string tag, bit iv, bit we, bit [4:0] rd,
                                 bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                                 bit rv, bit rwe, bit [4:0] rrd, bit [PTR_W:0] fc);
        exp_t e;
        bit   stl;
        int   kill;
        ent_t ne;
        @(negedge clk);
        rst             = 1'b0;
        sb.issue_valid  = iv;
        sb.issue_we     = we;
        sb.issue_rd     = rd;
        sb.rs1          = rs1;
        sb.use_rs1      = u1;
        sb.rs2          = rs2;
        sb.use_rs2      = u2;
        sb.retire_valid = rv;
        sb.retire_we    = rwe;
        sb.retire_rd    = rrd;
        sb.flush_cnt    = fc;
        stl = iv && ((u1 && modelHit(rs1, rv)) || (u2 && modelHit(rs2, rv)) ||
                     (model.size() == DEPTH && !rv) || fc != 0);
        e.stall    = stl;
        e.inflight = model.size();
        e.full     = (model.size() == DEPTH);
        e.err      = model_err;
        e.tag      = tag;
        exp_q.push_back(e);
        if (rv) begin
            if (model.size() == 0) model_err = 1'b1;
            else begin
                if (model[0].we != rwe || model[0].rd != rrd) model_err = 1'b1;
                void'(model.pop_front());
            end
        end
        kill = (int'(fc) < model.size()) ? int'(fc) : model.size();
        repeat (kill) void'(model.pop_back());
        if (iv && !stl) begin
            ne.we = we && (rd != 5'd0);
            ne.rd = rd;
            model.push_back(ne);
        end
    endtask

    task automatic issue(string tag, bit we, bit [4:0] rd, bit rv = 0, bit rwe = 0, bit [4:0] rrd = 0);
        applyStimulus(tag, 1, we, rd, 0, 0, 0, 0, rv, rwe, rrd, 0);
    endtask

    task automatic readReg(string tag, bit [4:0] rs, bit rv = 0, bit rwe = 0, bit [4:0] rrd = 0);
        applyStimulus(tag, 1, 0, 0, rs, 1, 0, 0, rv, rwe, rrd, 0);
    endtask

    task automatic retire(string tag, bit rwe, bit [4:0] rrd);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 1, rwe, rrd, 0);
    endtask

    task automatic idle(string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < DEPTH && model.size() > 0; k++) retire(tag, model[0].we, model[0].rd);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst             = 1'b1;
        sb.issue_valid  = 1'b0;
        sb.retire_valid = 1'b0;
        sb.flush_cnt    = '0;
        model.delete();
        model_err = 1'b0;
    endtask

    initial begin
        bit       iv, we, u1, u2, rv, rwe;
        bit [4:0] rd, rs1, rs2, rrd;
        bit [PTR_W:0] fc;

        sb.issue_valid = 0; sb.issue_we = 0; sb.issue_rd = 0;
        sb.rs1 = 0; sb.rs2 = 0; sb.use_rs1 = 0; sb.use_rs2 = 0;
        sb.retire_valid = 0; sb.retire_we = 0; sb.retire_rd = 0; sb.flush_cnt = 0;

        // RAW hazard on x5 held until writeback retires it.
        issue("raw.issue", 1, 5);
        readReg("raw.wait0", 5);
        readReg("raw.wait1", 5);
        readReg("raw.retire", 5, 1, 1, 5);
        readReg("raw.after", 5);
        drain("raw.drain");

        // x0 never blocks and is tracked as a non-writing entry.
        issue("x0.issue", 1, 0);
        readReg("x0.read", 0);
        retire("x0.retire", 0, 0);
        drain("x0.drain");
        idle("x0.idle");

        // Fill, stall on full, then issue alongside a retire with wrapping tail.
        for (int r = 1; r <= 4; r++) issue("fill", 1, 5'(r));
        issue("full.stall", 1, 5);
        issue("full.retire", 1, 5, 1, 1, 1);
        idle("full.hold");
        drain("full.drain");

        // Two writers of x7; only the second retire clears the hazard.
        issue("dup.w1", 1, 7);
        issue("dup.w2", 1, 7);
        readReg("dup.ret1", 7, 1, 1, 7);
        readReg("dup.still", 7);
        readReg("dup.ret2", 7, 1, 1, 7);
        readReg("dup.clear", 7);
        drain("dup.drain");

        // Squash two youngest while the oldest retires.
        issue("fl.w1", 1, 1);
        issue("fl.w2", 1, 2);
        issue("fl.w3", 1, 3);
        applyStimulus("fl.flush", 1, 0, 0, 3, 1, 0, 0, 1, 1, 1, 2);
        readReg("fl.read3", 3);
        drain("fl.drain");
        idle("fl.idle");

        // Underflow and head mismatch both latch order_err until reset.
        retire("err.under", 1, 3);
        idle("err.sticky0");
        issue("err.sticky1", 1, 9);
        doReset();
        idle("err.reset");
        issue("err.w4", 1, 4);
        retire("err.mis", 1, 6);
        idle("err.sticky2");
        doReset();

        // Random traffic against the reference queue.
        for (int c = 0; c < 400; c++) begin
            if (c % 80 == 79) doReset();
            iv  = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1);
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            rv  = (model.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            if (model.size() > 0) begin
                rwe = model[0].we;
                rrd = model[0].rd;
            end else begin
                rwe = $urandom_range(0, 1);
                rrd = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 29) == 0) rrd = rrd ^ 5'd1;
            fc = ($urandom_range(0, 9) == 0) ? (PTR_W+1)'($urandom_range(1, DEPTH)) : '0;
            applyStimulus("rand", iv, we, rd, rs1, u1, rs2, u2, rv, rwe, rrd, fc);
        end

        idle("final");
        @(negedge clk);
        #3;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- In-order in-flight tracker on the register-file read side of the 5-stage RV32I pipeline; sits in decode.
- Records destination registers of issued instructions. Stalls decode while a source operand has an outstanding write. Releases entries as writeback retires them.
- Counterpart to the writeback write port (RdW/ResultW/RegWriteW, written on negedge clk).

Parameters:
- DEPTH, 4, max in-flight instructions tracked (power of two, ≥2).
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- issue_valid  input  1  decode offers an instruction this cycle.
- issue_we  input  1  the offered instruction writes a register.
- issue_rd  input  5  destination register of the offered instruction.
- rs1  input  5  source register 1 of the offered instruction.
- rs2  input  5  source register 2 of the offered instruction.
- use_rs1  input  1  rs1 is read by the offered instruction.
- use_rs2  input  1  rs2 is read by the offered instruction.
- retire_valid  input  1  oldest in-flight instruction leaves writeback this cycle.
- retire_rd  input  5  RdW of the retiring instruction.
- retire_we  input  1  RegWriteW of the retiring instruction.
- flush_cnt  input  PTR_W+1  number of youngest entries to discard (branch squash), 0..DEPTH.
- stall  output  1  hold decode; instruction is not issued.
- inflight  output  PTR_W+1  current entry count.
- full  output  1  inflight == DEPTH.
- order_err  output  1  sticky; retire mismatch or underflow detected.

Behaviour:
- Storage: circular FIFO of DEPTH entries {we, rd}, with head/tail pointers and count. An entry with rd=0 is pushed with we forced to 0.
- Hazard: hit1 = use_rs1 & rs1≠0 & some valid entry has we=1 and rd==rs1; hit2 is the same for rs2.
- stall = issue_valid & (hit1 | hit2 | (full & !retire_valid) | flush_cnt≠0). Combinational from state and inputs.
- Push: on issue_valid & !stall, write the entry at tail, advance tail, count+1.
- Pop: on retire_valid & count>0, advance head, count-1.
  - If retire_rd≠head.rd or retire_we≠head.we, set order_err.
  - On retire_valid with count==0, set order_err; no pointer movement.
- Full with simultaneous pop: the push is allowed (stall term above). Count stays DEPTH.
- Flush: kills min(flush_cnt, count − pop) youngest entries. Tail moves back modulo DEPTH and count is reduced. Push is suppressed by stall. Pop applies to the oldest entry in the same cycle.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes below 0.
- Latency: a pushed entry blocks readers from the next cycle. A popped entry stops blocking from the next cycle, unless the optional feature is enabled.
- Reset: head=tail=count=0, all entry valid bits cleared, order_err=0. Hence stall=0 (with flush_cnt=0), inflight=0, full=0. Reset mid-operation discards all entries with no error.

Optional Feature:
- Macro SCOREBOARD_SAME_CYCLE_RELEASE_EN.
- Defined: in the hit calculation, the head entry is ignored when retire_valid is high that cycle. This relies on the negedge register-file write making the value readable in the same cycle, and removes one stall cycle.
- Undefined: the head entry blocks until popped; stall lasts one cycle longer.

Decomposition:
- Shared package rv32_pkg:
  - REG_ADDR_W=5
  - X0 constant
  - sb_entry_t typedef {logic we; logic [4:0] rd}
- One natural sub-module: sb_fifo, a generic circular FIFO with push/pop/rollback-by-n and count. regfile_scoreboard adds the hazard compare and error checking.

Test Plan:
- Reset, then issue ADDI rd=5 (we=1) → inflight=1 next cycle. Issue with rs1=5 → stall=1 until retire rd=5, we=1. Stall drops the cycle after retire (or in the retire cycle with the macro defined).
- Issue rd=0, we=1, then a reader with rs1=0 → no stall. Retire with rd=0, we=0 → order_err stays 0.
- Push 4 independent writers (rd=1..4) → full=1. Fifth issue without retire → stall=1. Fifth issue with retire_valid → accepted, inflight stays 4, tail wraps to 0.
- Two entries in flight with rd=7 (twice). Retire the first → a reader of x7 still stalls. Retire the second → stall clears.
- Three in flight (rd=1,2,3), flush_cnt=2 concurrent with retire of rd=1 → inflight=0. A reader of x3 no longer stalls.
- Retire with count=0, or retire_rd mismatching head (head rd=4, retire_rd=6) → order_err=1, sticky until rst.
